// File: rtl/flobuffer_pkg.sv
// Shared types and helpers for the timed output buffer.
package flobuffer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int FLOBUF_DEPTH_DEF = 4;

    // Level counter must represent 0..DEPTH inclusive.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/flobuffer_fifo.sv
// Word storage for the timed buffer: registered write, combinational head read,
// registered level/full/empty and a synchronous flush.
module flobuffer_fifo
    import flobuffer_pkg::*;
#(
    parameter int WIDTH = 23,
    parameter int DEPTH = FLOBUF_DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      wr_en,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      rd_en,
    output logic [WIDTH-1:0]          rd_data,
    output logic [level_w(DEPTH)-1:0] level,
    output logic                      full,
    output logic                      empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_nxt;
    logic             do_wr;
    logic             do_rd;

    // full is the registered state, so a pop at the same edge never makes room for a write.
    assign do_wr   = wr_en && !full && !flush;
    assign do_rd   = rd_en && !empty && !flush;
    assign rd_data = mem[rd_ptr];

    // Next occupancy from the accepted write/read pair.
    always_comb begin
        level_nxt = level;
        if (do_wr && !do_rd) begin
            level_nxt = level + 1'b1;
        end else if (!do_wr && do_rd) begin
            level_nxt = level - 1'b1;
        end
    end

    // Pointers and status flags; flush returns everything to the empty state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level_nxt;
            full  <= (level_nxt == LW'(DEPTH));
            empty <= (level_nxt == '0);
        end
    end

    // Storage array write; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/flobuffer_timed.sv
// Timed output buffer: queues {delay, data} words and emits each one as a
// single-cycle strobe delay+1 cycles after the previous emission.
//
//  state | meaning
//  IDLE  | no countdown running; pops the head word when allowed
//  WAIT  | counting down the popped word's delay; emits when the count expires
module flobuffer_timed
    import flobuffer_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int DELAY_W = 7,
    parameter int DEPTH   = FLOBUF_DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_W-1:0]         data_i,
    input  logic [DELAY_W-1:0]        delay_i,
    input  logic                      valid_i,
    input  logic                      direct_i,
    input  logic                      hold_i,
    input  logic                      flush_i,
    output logic                      ready_o,
    output logic [DATA_W-1:0]         data_o,
    output logic                      stb_o,
    output logic                      empty_o,
    output logic                      full_o,
    output logic                      err_o,
    output logic [level_w(DEPTH)-1:0] level_o
);

    localparam int WORD_W = DATA_W + DELAY_W;

    state_t              state;
    state_t              state_nxt;
    logic [DELAY_W-1:0]  cnt;
    logic [DELAY_W-1:0]  cnt_nxt;
    logic [DATA_W-1:0]   pend_data;
    logic [WORD_W-1:0]   head_word;
    logic [DATA_W-1:0]   head_data;
    logic [DELAY_W-1:0]  head_delay;
    logic [DATA_W-1:0]   emit_data;
    logic                pop;
    logic                eng_emit;

    flobuffer_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush_i),
        .wr_en   (valid_i),
        .wr_data ({delay_i, data_i}),
        .rd_en   (pop),
        .rd_data (head_word),
        .level   (level_o),
        .full    (full_o),
        .empty   (empty_o)
    );

    assign ready_o    = !full_o;
    assign head_delay = head_word[WORD_W-1 -: DELAY_W];
    assign head_data  = head_word[DATA_W-1:0];
    // Zero-delay words go straight from the head; delayed words were latched at pop.
    assign emit_data  = (state == IDLE) ? head_data : pend_data;

    // Engine state and countdown register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, pop and emit decisions; a direct word defers any due emission.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pop       = 1'b0;
        eng_emit  = 1'b0;
        if (flush_i) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty_o && !hold_i && !direct_i) begin
                        pop = 1'b1;
                        if (head_delay == '0) begin
                            eng_emit = 1'b1;
                        end else begin
                            cnt_nxt   = head_delay;
                            state_nxt = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!hold_i) begin
                        if (cnt == DELAY_W'(1)) begin
                            if (!direct_i) begin
                                eng_emit  = 1'b1;
                                cnt_nxt   = '0;
                                state_nxt = IDLE;
                            end
                        end else begin
                            cnt_nxt = cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Output registers, pending word latch and write-rejection strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_o    <= '0;
            stb_o     <= 1'b0;
            err_o     <= 1'b0;
            pend_data <= '0;
        end else begin
            stb_o <= direct_i || eng_emit;
            err_o <= valid_i && full_o && !flush_i;
            if (pop) begin
                pend_data <= head_data;
            end
            if (direct_i) begin
                data_o <= data_i;
            end else if (eng_emit) begin
                data_o <= emit_data;
            end
        end
    end

endmodule

// File: tb/tb_flobuffer_timed.sv
// Scenario bench for flobuffer_timed: expected strobes (data and edge number)
// are queued as stimulus is driven and matched by a strobe monitor.
module tb_flobuffer_timed;

    localparam int DATA_W  = 16;
    localparam int DELAY_W = 7;
    localparam int DEPTH   = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [DATA_W-1:0]  data_i;
    logic [DELAY_W-1:0] delay_i;
    logic               valid_i;
    logic               direct_i;
    logic               hold_i;
    logic               flush_i;
    logic               ready_o;
    logic [DATA_W-1:0]  data_o;
    logic               stb_o;
    logic               empty_o;
    logic               full_o;
    logic               err_o;
    logic [2:0]         level_o;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                at;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_stb    = 0;

    flobuffer_timed #(
        .DATA_W  (DATA_W),
        .DELAY_W (DELAY_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_i   (data_i),
        .delay_i  (delay_i),
        .valid_i  (valid_i),
        .direct_i (direct_i),
        .hold_i   (hold_i),
        .flush_i  (flush_i),
        .ready_o  (ready_o),
        .data_o   (data_o),
        .stb_o    (stb_o),
        .empty_o  (empty_o),
        .full_o   (full_o),
        .err_o    (err_o),
        .level_o  (level_o)
    );

    always #5 clk = ~clk;

    // Edge counter: after rising edge k, cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: every strobe must match the oldest expected emission.
    always @(negedge clk) begin : mon
        exp_t e;
        if (stb_o === 1'b1) begin
            n_stb++;
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_stb: data_o=%h at edge %0d, required no strobe", data_o, cyc);
            end else begin
                n_pass++;
                e = sb.pop_front();
                n_checks++;
                if (data_o !== e.data)
                    $display("FAIL stb_data: data_o=%h, required %h", data_o, e.data);
                else
                    n_pass++;
                n_checks++;
                if (cyc !== e.at)
                    $display("FAIL stb_time: strobe at edge %0d, required edge %0d", cyc, e.at);
                else
                    n_pass++;
            end
        end
    end

    task automatic wait_drain(input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            $display("FAIL drain: %0d strobes outstanding, required 0", sb.size());
            sb.delete();
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (data_o !== 16'h0) $display("FAIL rst_data: %h, required 0", data_o); else n_pass++;
        n_checks++; if (stb_o !== 1'b0) $display("FAIL rst_stb: %b, required 0", stb_o); else n_pass++;
        n_checks++; if (err_o !== 1'b0) $display("FAIL rst_err: %b, required 0", err_o); else n_pass++;
        n_checks++; if (full_o !== 1'b0) $display("FAIL rst_full: %b, required 0", full_o); else n_pass++;
        n_checks++; if (empty_o !== 1'b1) $display("FAIL rst_empty: %b, required 1", empty_o); else n_pass++;
        n_checks++; if (level_o !== 3'd0) $display("FAIL rst_level: %0d, required 0", level_o); else n_pass++;
        n_checks++; if (ready_o !== 1'b1) $display("FAIL rst_ready: %b, required 1", ready_o); else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (empty_o !== 1'b1) $display("FAIL post_rst_empty: %b, required 1", empty_o); else n_pass++;
    endtask

    task automatic test_single();
        int n;
        @(negedge clk);
        n = cyc + 1;
        data_i = 16'hA5A5; delay_i = 7'd3; valid_i = 1'b1;
        sb.push_back('{data: 16'hA5A5, at: n + 4});
        @(negedge clk);
        valid_i = 1'b0;
        n_checks++; if (level_o !== 3'd1) $display("FAIL single_level: %0d, required 1", level_o); else n_pass++;
        n_checks++; if (empty_o !== 1'b0) $display("FAIL single_empty_clr: %b, required 0", empty_o); else n_pass++;
        @(negedge clk);
        n_checks++; if (empty_o !== 1'b1) $display("FAIL single_empty_pop: %b, required 1", empty_o); else n_pass++;
        wait_drain(20);
    endtask

    task automatic test_stream();
        int n;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if (full_o !== 1'b0) $display("FAIL stream_full: %b, required 0", full_o); else n_pass++;
            n = cyc + 1;
            data_i = 16'(i + 1); delay_i = 7'd0; valid_i = 1'b1;
            sb.push_back('{data: 16'(i + 1), at: n + 1});
        end
        @(negedge clk);
        valid_i = 1'b0;
        repeat (4) begin
            n_checks++; if (full_o !== 1'b0) $display("FAIL stream_full: %b, required 0", full_o); else n_pass++;
            @(negedge clk);
        end
        wait_drain(20);
    endtask

    task automatic test_hold_full();
        int t;
        @(negedge clk);
        hold_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_i = 16'(i + 1); delay_i = 7'd1; valid_i = 1'b1;
            @(negedge clk);
            if (i == 3) begin
                n_checks++; if (full_o !== 1'b1) $display("FAIL hold_full: %b, required 1", full_o); else n_pass++;
                n_checks++; if (level_o !== 3'd4) $display("FAIL hold_level: %0d, required 4", level_o); else n_pass++;
                n_checks++; if (ready_o !== 1'b0) $display("FAIL hold_ready: %b, required 0", ready_o); else n_pass++;
                n_checks++; if (err_o !== 1'b0) $display("FAIL hold_err_early: %b, required 0", err_o); else n_pass++;
            end
            if (i == 4) begin
                n_checks++; if (err_o !== 1'b1) $display("FAIL hold_err: %b, required 1", err_o); else n_pass++;
                n_checks++; if (level_o !== 3'd4) $display("FAIL hold_level_rej: %0d, required 4", level_o); else n_pass++;
            end
        end
        valid_i = 1'b0;
        @(negedge clk);
        n_checks++; if (err_o !== 1'b0) $display("FAIL hold_err_pulse: %b, required 0", err_o); else n_pass++;
        hold_i = 1'b0;
        t = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            t = t + 1;
            sb.push_back('{data: 16'(i + 1), at: t});
            t = t + 1;
        end
        wait_drain(30);
    endtask

    task automatic test_hold_mid();
        int n;
        @(negedge clk);
        n = cyc + 1;
        data_i = 16'h5A5A; delay_i = 7'd5; valid_i = 1'b1;
        sb.push_back('{data: 16'h5A5A, at: n + 9});
        @(negedge clk);
        valid_i = 1'b0;
        repeat (2) @(negedge clk);
        hold_i = 1'b1;
        repeat (3) @(negedge clk);
        hold_i = 1'b0;
        wait_drain(20);
    endtask

    task automatic test_direct();
        int n;
        @(negedge clk);
        n = cyc + 1;
        data_i = 16'h1234; delay_i = 7'd2; valid_i = 1'b1;
        sb.push_back('{data: 16'hBEEF, at: n + 3});
        sb.push_back('{data: 16'h1234, at: n + 4});
        @(negedge clk);
        valid_i = 1'b0;
        repeat (2) @(negedge clk);
        direct_i = 1'b1; data_i = 16'hBEEF;
        @(negedge clk);
        direct_i = 1'b0;
        wait_drain(20);
        n_checks++; if (data_o !== 16'h1234) $display("FAIL direct_held: %h, required 1234", data_o); else n_pass++;
    endtask

    task automatic test_flush_reset();
        int s;
        @(negedge clk);
        data_i = 16'hAAAA; delay_i = 7'd6; valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            data_i = 16'hB000 + 16'(i); delay_i = 7'd0; valid_i = 1'b1;
        end
        @(negedge clk);
        n_checks++; if (level_o !== 3'd3) $display("FAIL flush_pre_level: %0d, required 3", level_o); else n_pass++;
        flush_i = 1'b1; data_i = 16'hEEEE; valid_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0; valid_i = 1'b0;
        s = n_stb;
        n_checks++; if (level_o !== 3'd0) $display("FAIL flush_level: %0d, required 0", level_o); else n_pass++;
        n_checks++; if (empty_o !== 1'b1) $display("FAIL flush_empty: %b, required 1", empty_o); else n_pass++;
        n_checks++; if (err_o !== 1'b0) $display("FAIL flush_err: %b, required 0", err_o); else n_pass++;
        repeat (15) @(negedge clk);
        n_checks++; if (n_stb !== s) $display("FAIL flush_stb: %0d strobes, required 0", n_stb - s); else n_pass++;

        data_i = 16'hCCCC; delay_i = 7'd5; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (data_o !== 16'h0) $display("FAIL mid_rst_data: %h, required 0", data_o); else n_pass++;
        n_checks++; if (stb_o !== 1'b0) $display("FAIL mid_rst_stb: %b, required 0", stb_o); else n_pass++;
        n_checks++; if (empty_o !== 1'b1) $display("FAIL mid_rst_empty: %b, required 1", empty_o); else n_pass++;
        n_checks++; if (level_o !== 3'd0) $display("FAIL mid_rst_level: %0d, required 0", level_o); else n_pass++;
        n_checks++; if (full_o !== 1'b0) $display("FAIL mid_rst_full: %b, required 0", full_o); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        s = n_stb;
        repeat (12) @(negedge clk);
        n_checks++; if (n_stb !== s) $display("FAIL mid_rst_stb_after: %0d strobes, required 0", n_stb - s); else n_pass++;
        n_checks++; if (empty_o !== 1'b1) $display("FAIL mid_rst_empty_after: %b, required 1", empty_o); else n_pass++;
        wait_drain(5);
    endtask

    initial begin
        rst_n    = 1'b0;
        data_i   = '0;
        delay_i  = '0;
        valid_i  = 1'b0;
        direct_i = 1'b0;
        hold_i   = 1'b0;
        flush_i  = 1'b0;
        test_reset();
        test_single();
        test_stream();
        test_hold_full();
        test_hold_mid();
        test_direct();
        test_flush_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench still running at %0t, required completion", $time);
        $fatal(1, "timeout");
    end

endmodule
